// File: rtl/i2c_seq_pkg.sv
// ============================================================================
// i2c_seq_pkg: shared types for the I2C register sequencer. Revision 1.0
// ============================================================================
`default_nettype none

package i2c_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR_W = 3'd1,
      ST_REG    = 3'd2,
      ST_WDATA  = 3'd3,
      ST_ADDR_R = 3'd4,
      ST_RDATA  = 3'd5,
      ST_DONE   = 3'd6
   } seq_state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_NACK    = 2'b01,
      ERR_BUS     = 2'b10,
      ERR_TIMEOUT = 2'b11
   } rsp_err_e;

   typedef logic [1:0] byte_idx_t;

endpackage

`default_nettype wire

// File: rtl/i2c_seq_timeout.sv
// ============================================================================
// i2c_seq_timeout: per-byte watchdog, flags expiry at TIMEOUT_CYCLES-1. Revision 1.0
// ============================================================================
`default_nettype none

module i2c_seq_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
   input  logic clk_in,
   input  logic reset_n,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = (cnt_q == LIMIT);

   // Saturate at the limit so expiry stays visible until the sequencer reacts.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (tick && !expired) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/i2c_reg_sequencer.sv
// ============================================================================
// i2c_reg_sequencer: register read/write sequencer driving a byte-level I2C master. Revision 1.0
// ============================================================================
`default_nettype none

module i2c_reg_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4800000
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [6:0]  req_dev_addr,
   input  logic [7:0]  req_reg_addr,
   input  logic [7:0]  req_wr_data,
   input  logic [1:0]  req_rd_len,
   output logic        rsp_valid,
   output logic [1:0]  rsp_err,
   output logic [31:0] rsp_rd_data,
   input  logic        i2c_transfer_ready,
   input  logic        i2c_interrupt,
   input  logic        i2c_transaction_complete,
   input  logic        i2c_nack,
   input  logic        i2c_start_err,
   input  logic        i2c_arbitration_err,
   input  logic [7:0]  i2c_data_rx,
   output logic        i2c_transfer_start,
   output logic        i2c_transfer_continues,
   output logic        i2c_mode,
   output logic [7:0]  i2c_data_tx
);

   seq_state_e  state_q, state_d;
   rsp_err_e    err_q, err_d;
   logic        write_q, write_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [1:0]  rd_len_q, rd_len_d;
   byte_idx_t   idx_q, idx_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        armed_q, armed_d;

   logic byte_done;
   logic bus_err;
   logic busy;
   logic last_byte;
   logic to_clear;
   logic to_tick;
   logic to_expired;

   assign byte_done = i2c_interrupt && i2c_transaction_complete;
   assign bus_err   = i2c_start_err || i2c_arbitration_err;
   assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign last_byte = (idx_q == rd_len_q);
   assign to_clear  = byte_done || (state_d != state_q);
   assign to_tick   = busy;

   i2c_seq_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .clear  (to_clear),
      .tick   (to_tick),
      .expired(to_expired)
   );

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      write_d   = write_q;
      dev_d     = dev_q;
      reg_d     = reg_q;
      wdata_d   = wdata_q;
      rd_len_d  = rd_len_q;
      idx_d     = idx_q;
      rd_data_d = rd_data_q;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d   = ST_ADDR_W;
               write_d   = req_write;
               dev_d     = req_dev_addr;
               reg_d     = req_reg_addr;
               wdata_d   = req_wr_data;
               rd_len_d  = req_rd_len;
               idx_d     = '0;
               err_d     = ERR_OK;
               rd_data_d = '0;
            end
         end
         ST_ADDR_W: if (byte_done) state_d = ST_REG;
         ST_REG:    if (byte_done) state_d = write_q ? ST_WDATA : ST_ADDR_R;
         ST_WDATA: begin
            if (byte_done) begin
               state_d = ST_DONE;
               err_d   = ERR_OK;
            end
         end
         ST_ADDR_R: if (byte_done) state_d = ST_RDATA;
         ST_RDATA: begin
            // The master NACKs the final read byte itself, so nack is not an error here.
            if (byte_done) begin
               rd_data_d[{idx_q, 3'b000} +: 8] = i2c_data_rx;
               if (last_byte) begin
                  state_d = ST_DONE;
                  err_d   = ERR_OK;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (busy) begin
         if (bus_err) begin
            state_d = ST_DONE;
            err_d   = ERR_BUS;
         end else if (byte_done && i2c_nack && (state_q != ST_RDATA)) begin
            state_d = ST_DONE;
            err_d   = ERR_NACK;
         end else if (!byte_done && to_expired) begin
            state_d = ST_DONE;
            err_d   = ERR_TIMEOUT;
         end
      end

      // Keep start asserted once the master has signalled ready for the address byte.
      armed_d = (state_q == ST_ADDR_W) && (state_d == ST_ADDR_W) &&
                (armed_q || i2c_transfer_ready);
   end

   always_comb begin
      i2c_transfer_start     = 1'b0;
      i2c_transfer_continues = 1'b0;
      i2c_mode               = 1'b0;
      i2c_data_tx            = 8'h00;
      unique case (state_q)
         ST_ADDR_W: begin
            i2c_transfer_start     = i2c_transfer_ready || armed_q;
            i2c_transfer_continues = 1'b1;
            i2c_data_tx            = {dev_q, 1'b0};
         end
         ST_REG: begin
            i2c_transfer_continues = write_q;
            i2c_data_tx            = reg_q;
         end
         ST_WDATA: begin
            i2c_data_tx = wdata_q;
         end
         ST_ADDR_R: begin
            i2c_transfer_start     = 1'b1;
            i2c_transfer_continues = 1'b1;
            i2c_data_tx            = {dev_q, 1'b1};
         end
         ST_RDATA: begin
            i2c_mode               = 1'b1;
            i2c_transfer_continues = !last_byte;
         end
         default: begin
         end
      endcase
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign rsp_valid   = (state_q == ST_DONE);
   assign rsp_err     = err_q;
   assign rsp_rd_data = rd_data_q;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         err_q     <= ERR_OK;
         write_q   <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         wdata_q   <= '0;
         rd_len_q  <= '0;
         idx_q     <= '0;
         rd_data_q <= '0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         write_q   <= write_d;
         dev_q     <= dev_d;
         reg_q     <= reg_d;
         wdata_q   <= wdata_d;
         rd_len_q  <= rd_len_d;
         idx_q     <= idx_d;
         rd_data_q <= rd_data_d;
         armed_q   <= armed_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_sequencer.sv
// ============================================================================
// tb_i2c_reg_sequencer: scoreboard bench for the I2C register sequencer. Revision 1.0
// ============================================================================
`default_nettype none

module tb_i2c_reg_sequencer;

   localparam int unsigned TO = 100;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [6:0]  req_dev_addr;
   logic [7:0]  req_reg_addr, req_wr_data;
   logic [1:0]  req_rd_len;
   logic        rsp_valid;
   logic [1:0]  rsp_err;
   logic [31:0] rsp_rd_data;
   logic        i2c_transfer_ready, i2c_interrupt, i2c_transaction_complete;
   logic        i2c_nack, i2c_start_err, i2c_arbitration_err;
   logic [7:0]  i2c_data_rx, i2c_data_tx;
   logic        i2c_transfer_start, i2c_transfer_continues, i2c_mode;

   i2c_reg_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_in                  (clk_in),
      .reset_n                 (reset_n),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_write               (req_write),
      .req_dev_addr            (req_dev_addr),
      .req_reg_addr            (req_reg_addr),
      .req_wr_data             (req_wr_data),
      .req_rd_len              (req_rd_len),
      .rsp_valid               (rsp_valid),
      .rsp_err                 (rsp_err),
      .rsp_rd_data             (rsp_rd_data),
      .i2c_transfer_ready      (i2c_transfer_ready),
      .i2c_interrupt           (i2c_interrupt),
      .i2c_transaction_complete(i2c_transaction_complete),
      .i2c_nack                (i2c_nack),
      .i2c_start_err           (i2c_start_err),
      .i2c_arbitration_err     (i2c_arbitration_err),
      .i2c_data_rx             (i2c_data_rx),
      .i2c_transfer_start      (i2c_transfer_start),
      .i2c_transfer_continues  (i2c_transfer_continues),
      .i2c_mode                (i2c_mode),
      .i2c_data_tx             (i2c_data_tx)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [1:0]  err;
      logic [31:0] data;
   } rsp_t;

   typedef struct packed {
      logic       start;
      logic       cont;
      logic       mode;
      logic       chk_tx;
      logic [7:0] tx;
   } cmd_t;

   rsp_t rsp_q[$];
   cmd_t cmd_q[$];
   rsp_t mon_rsp;
   cmd_t mon_cmd;
   logic prev_valid = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every completion pulse.
   always @(negedge clk_in) begin
      if (rsp_valid) begin
         if (rsp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_q.size()), 32'd1);
         end else begin
            mon_rsp = rsp_q.pop_front();
            check("rsp_err", 32'(rsp_err), 32'(mon_rsp.err));
            check("rsp_rd_data", rsp_rd_data, mon_rsp.data);
         end
         check("rsp_pulse_width", 32'(prev_valid), 32'd0);
      end
      prev_valid = rsp_valid;
   end

   // Command monitor: the command presented during each byte-complete event.
   always @(negedge clk_in) begin
      if (reset_n && i2c_interrupt && i2c_transaction_complete) begin
         if (cmd_q.size() == 0) begin
            check("cmd_unexpected", 32'(cmd_q.size()), 32'd1);
         end else begin
            mon_cmd = cmd_q.pop_front();
            check("cmd_start", 32'(i2c_transfer_start), 32'(mon_cmd.start));
            check("cmd_continues", 32'(i2c_transfer_continues), 32'(mon_cmd.cont));
            check("cmd_mode", 32'(i2c_mode), 32'(mon_cmd.mode));
            if (mon_cmd.chk_tx) check("cmd_data_tx", 32'(i2c_data_tx), 32'(mon_cmd.tx));
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input logic [1:0] len, input logic push,
                        input logic [1:0] e_err, input logic [31:0] e_data);
      int   guard = 0;
      rsp_t r;
      while (!req_ready && guard < 500) begin
         tick();
         guard++;
      end
      check("req_ready_before_issue", 32'(req_ready), 32'd1);
      if (push) begin
         r.err  = e_err;
         r.data = e_data;
         rsp_q.push_back(r);
      end
      req_valid    = 1'b1;
      req_write    = wr;
      req_dev_addr = dev;
      req_reg_addr = rg;
      req_wr_data  = wd;
      req_rd_len   = len;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic byte_ev(input logic nack, input logic [7:0] rx, input logic st, input logic ct,
                          input logic md, input logic chk, input logic [7:0] tx, input int gap);
      cmd_t c;
      c.start  = st;
      c.cont   = ct;
      c.mode   = md;
      c.chk_tx = chk;
      c.tx     = tx;
      cmd_q.push_back(c);
      repeat (gap) tick();
      i2c_interrupt            = 1'b1;
      i2c_transaction_complete = 1'b1;
      i2c_nack                 = nack;
      i2c_data_rx              = rx;
      tick();
      i2c_interrupt            = 1'b0;
      i2c_transaction_complete = 1'b0;
      i2c_nack                 = 1'b0;
   endtask

   // Returns at the start of the n-th cycle (0-based) in which start has been high.
   task automatic stall(input int n);
      int seen = 0;
      for (int i = 0; i < 400 && seen < n; i++) begin
         @(negedge clk_in);
         if (i2c_transfer_start) seen++;
      end
      tick();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_rsp_rd_data"}, rsp_rd_data, 32'd0);
      check({tag, "_start"}, 32'(i2c_transfer_start), 32'd0);
      check({tag, "_continues"}, 32'(i2c_transfer_continues), 32'd0);
      check({tag, "_mode"}, 32'(i2c_mode), 32'd0);
      check({tag, "_data_tx"}, 32'(i2c_data_tx), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      req_valid = 0; req_write = 0; req_dev_addr = 0; req_reg_addr = 0;
      req_wr_data = 0; req_rd_len = 0;
      i2c_transfer_ready = 1; i2c_interrupt = 0; i2c_transaction_complete = 0;
      i2c_nack = 0; i2c_start_err = 0; i2c_arbitration_err = 0; i2c_data_rx = 0;
      repeat (3) tick();
      check_idle_outputs("reset");
      reset_n = 1'b1;
      tick();

      // Single-byte read; a lone interrupt without transaction_complete is not a byte event.
      issue(1'b0, 7'h6B, 8'h08, 8'h00, 2'd0, 1'b1, 2'b00, 32'h0000005A);
      i2c_interrupt = 1'b1;
      tick();
      i2c_interrupt = 1'b0;
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD6, 2);
      byte_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 2);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD7, 2);
      byte_ev(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2);
      repeat (3) tick();
      check("hold_rsp_err", 32'(rsp_err), 32'd0);
      check("hold_rsp_rd_data", rsp_rd_data, 32'h0000005A);

      // Write, start gated by transfer_ready, and a request offered while busy.
      i2c_transfer_ready = 1'b0;
      issue(1'b1, 7'h6B, 8'h00, 8'h30, 2'd0, 1'b1, 2'b00, 32'h0);
      tick();
      check("start_waits_ready", 32'(i2c_transfer_start), 32'd0);
      i2c_transfer_ready = 1'b1;
      tick();
      i2c_transfer_ready = 1'b0;
      #1;
      check("start_held_after_ready", 32'(i2c_transfer_start), 32'd1);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD6, 1);
      req_valid = 1'b1; req_write = 1'b0; req_dev_addr = 7'h7F; req_reg_addr = 8'hFF;
      tick();
      req_valid = 1'b0;
      byte_ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2);
      byte_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 2);
      i2c_transfer_ready = 1'b1;
      tick();

      // Three-byte read.
      issue(1'b0, 7'h50, 8'h10, 8'h00, 2'd2, 1'b1, 2'b00, 32'h00332211);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 2);
      byte_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 2);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 2);
      byte_ev(1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2);
      byte_ev(1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2);
      byte_ev(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2);
      tick();

      // NACK on the address byte: response one cycle after the event, then no start.
      issue(1'b1, 7'h20, 8'h01, 8'h55, 2'd0, 1'b1, 2'b01, 32'h0);
      byte_ev(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 2);
      check("nack_rsp_valid_next_cycle", 32'(rsp_valid), 32'd1);
      check("nack_rsp_err_next_cycle", 32'(rsp_err), 32'd1);
      check("nack_end_continues", 32'(i2c_transfer_continues), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("nack_no_start", 32'(i2c_transfer_start), 32'd0);
         tick();
      end

      // NACK on the register byte of a read.
      issue(1'b0, 7'h21, 8'h33, 8'h00, 2'd1, 1'b1, 2'b01, 32'h0);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h42, 2);
      byte_ev(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 2);
      tick();

      // Timeout with no byte event: 100 cycles of start, then err 11.
      issue(1'b1, 7'h11, 8'h00, 8'h00, 2'd0, 1'b1, 2'b11, 32'h0);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_in);
         if (rsp_valid) break;
         if (i2c_transfer_start) n++;
      end
      check("timeout_start_cycles", 32'(n), 32'd100);
      tick();

      // Arbitration error in the same cycle the timeout fires: bus error wins.
      issue(1'b1, 7'h12, 8'h00, 8'h00, 2'd0, 1'b1, 2'b10, 32'h0);
      stall(99);
      i2c_arbitration_err = 1'b1;
      tick();
      i2c_arbitration_err = 1'b0;
      tick();

      // NACK in the same cycle the timeout fires: nack wins.
      issue(1'b1, 7'h13, 8'h00, 8'h00, 2'd0, 1'b1, 2'b01, 32'h0);
      stall(99);
      byte_ev(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h26, 0);
      tick();

      // Start error while sending the register byte.
      issue(1'b0, 7'h33, 8'h44, 8'h00, 2'd0, 1'b1, 2'b10, 32'h0);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 2);
      tick();
      i2c_start_err = 1'b1;
      tick();
      i2c_start_err = 1'b0;
      tick();

      // Reset mid-read, then a normal write.
      issue(1'b0, 7'h6B, 8'h08, 8'h00, 2'd1, 1'b0, 2'b00, 32'h0);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD6, 2);
      byte_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h08, 2);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD7, 2);
      byte_ev(1'b0, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2);
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      issue(1'b1, 7'h6B, 8'h00, 8'h30, 2'd0, 1'b1, 2'b00, 32'h0);
      byte_ev(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD6, 2);
      byte_ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 2);
      byte_ev(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h30, 2);
      repeat (4) tick();

      check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/i2c_reg_sequencer.md
I2C_REG_SEQUENCER -- requirements
Module: i2c_reg_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with clock port clk_in and reset port reset_n.
REQ-002 Parameter TIMEOUT_CYCLES, default 4800000, SHALL set the clk_in cycles allowed per byte before a timeout (100 ms at 48 MHz).
REQ-003 Ports, listed as name, direction, width, meaning:
 - clk_in  in  1  clock.
 - reset_n  in  1  async active-low reset.
 - req_valid  in  1  request offered.
 - req_ready  out  1  sequencer idle.
 - req_write  in  1  1 = register write, 0 = register read.
 - req_dev_addr  in  7  7-bit device address.
 - req_reg_addr  in  8  register pointer.
 - req_wr_data  in  8  write byte.
 - req_rd_len  in  2  read length minus 1 (1..4 bytes).
 - rsp_valid  out  1  one-cycle completion pulse.
 - rsp_err  out  2  00 ok, 01 nack, 10 bus error, 11 timeout.
 - rsp_rd_data  out  32  read bytes; first byte in [7:0].
 - i2c_transfer_ready  in  1  master can accept a start.
 - i2c_interrupt, i2c_transaction_complete, i2c_nack, i2c_start_err, i2c_arbitration_err  in  1 each  master status.
 - i2c_data_rx  in  8  received byte.
 - i2c_transfer_start, i2c_transfer_continues, i2c_mode  out  1 each  master command (mode 1 = read).
 - i2c_data_tx  out  8  byte to transmit.

Function
REQ-004 A byte-complete event E SHALL be defined as i2c_interrupt && i2c_transaction_complete in the same cycle.
REQ-005 req_ready SHALL be 1 only in IDLE; on req_valid && req_ready all req_* fields SHALL be captured; req_valid while busy SHALL be ignored.
REQ-006 States SHALL be IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, DONE.
REQ-007 IDLE->ADDR_W on accept. ADDR_W SHALL wait for i2c_transfer_ready, then drive start=1, continues=1, mode=0, data_tx={dev,0}; on E && !nack go to REG.
REQ-008 REG SHALL drive start=0, mode=0, data_tx=reg. continues=1 for a write (then WDATA on E && !nack). continues=0 for a read (then ADDR_R on E && !nack).
REQ-009 WDATA SHALL drive start=0, continues=0, data_tx=wr_data; on E && !nack go to DONE with err 00.
REQ-010 ADDR_R SHALL drive start=1, continues=1, mode=0, data_tx={dev,1}; on E && !nack go to RDATA.
REQ-011 RDATA SHALL drive start=0, mode=1; continues=1 for non-last bytes and 0 for the last byte. Each E SHALL store i2c_data_rx into byte lane idx, with idx counting 0..rd_len.
REQ-012 In RDATA, i2c_nack=1 is required only on the last byte's E (master NACK), which SHALL go to DONE with err 00.
REQ-013 i2c_nack on E during ADDR_W, REG, WDATA or ADDR_R SHALL end the request with err 01.
REQ-014 i2c_start_err or i2c_arbitration_err in any non-IDLE state SHALL end the request with err 10.
REQ-015 A per-byte counter SHALL clear on each E and on every state change; reaching TIMEOUT_CYCLES-1 SHALL end the request with err 11.
REQ-016 Error priority in one cycle SHALL be 10 > 01 > 11.
REQ-017 Ending a request SHALL drive start=0 and continues=0 in the next cycle.
REQ-018 DONE SHALL pulse rsp_valid for one cycle and return to IDLE.
REQ-019 rsp_err and rsp_rd_data SHALL hold until the next accept.
REQ-020 Unread rsp_rd_data lanes SHALL be 0.
REQ-021 Latency from E to the next command change SHALL be 1 cycle.

Reset
REQ-022 Asserting reset_n=0 at any time, including mid-transfer, SHALL force: state IDLE, req_ready 1, rsp_valid 0, rsp_err 00, rsp_rd_data 0, i2c_transfer_start 0, i2c_transfer_continues 0, i2c_mode 0, i2c_data_tx 0x00, counters 0.

Structure
REQ-023 Package i2c_seq_pkg SHALL hold the state enum, the rsp_err code enum, and the byte-index type.
REQ-024 The timeout counter SHALL be the sub-module i2c_seq_timeout, with ports clear, tick and expired.

Verification
REQ-025 Read, dev 0x6B, reg 0x08, rd_len 0, rx 0x5A -> data_tx sequence D6,08,D7; continues sequence 1,0,1,0; rsp_rd_data 0x0000005A; rsp_err 00.
REQ-026 Write, dev 0x6B, reg 0x00, data 0x30 -> data_tx sequence D6,00,30; continues sequence 1,1,0; rsp_err 00.
REQ-027 Read, rd_len 2, rx 11,22,33 -> read-byte continues sequence 1,1,0; rsp_rd_data 0x00332211.
REQ-028 NACK on the address byte -> rsp_err 01 one cycle after E; no further start issued.
REQ-029 TIMEOUT_CYCLES=100 with no E after start -> rsp_err 11 at the 100th cycle; arbitration_err in the same cycle -> rsp_err 10.
REQ-030 reset_n pulsed low during RDATA -> all outputs at reset values; the next request completes normally.
